urna: RTL and testbench

URNA -- requirements
Module: urna

---
 rtl/urna.sv | 97 +++++++++
 tb/tb_urna.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/urna.sv
// Two-digit electronic ballot box: tallies candidate 1, candidate 2 and null votes.
// Latency: a confirm updates its counter and pulses VoteStatus on the following cycle.
// Backpressure: none; one step is taken per cycle while valid is high, and CLOSED ignores all input.
//
// Ports:
//   clk, rst_n          - clock (rising edge) and asynchronous active-low reset
//   digit[3:0], valid   - digit entry; valid with two digits held confirms the vote
//   swap                - voter correction: drops the digits entered so far
//   finish              - closes the election (sticky until reset)
//   VoteStatus          - one-cycle pulse after each counted vote
//   contadorC1/C2/Null  - 8-bit vote tallies
// Build option: define URNA_SATURATE_EN to make the tallies stop at 255 instead of wrapping.
module urna #(
    parameter logic [7:0] CODE_C1 = 8'h13,
    parameter logic [7:0] CODE_C2 = 8'h22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       valid,
    input  logic       swap,
    input  logic       finish,
    output logic       VoteStatus,
    output logic [7:0] contadorC1,
    output logic [7:0] contadorC2,
    output logic [7:0] contadorNull
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        CLOSED = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] tens;
    logic [3:0] units;

    function automatic logic [7:0] bump(input logic [7:0] cnt);
`ifdef URNA_SATURATE_EN
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
`else
        return cnt + 8'd1;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tens         <= 4'd0;
            units        <= 4'd0;
            VoteStatus   <= 1'b0;
            contadorC1   <= 8'd0;
            contadorC2   <= 8'd0;
            contadorNull <= 8'd0;
        end else begin
            VoteStatus <= 1'b0;
            if (state != CLOSED) begin
                // finish beats swap beats valid; a confirm coinciding with finish is lost.
                if (finish) begin
                    state <= CLOSED;
                    tens  <= 4'd0;
                    units <= 4'd0;
                end else if (swap && state != IDLE) begin
                    state <= IDLE;
                    tens  <= 4'd0;
                    units <= 4'd0;
                end else if (valid) begin
                    case (state)
                        IDLE: begin
                            tens  <= digit;
                            state <= FIRST;
                        end
                        FIRST: begin
                            units <= digit;
                            state <= SECOND;
                        end
                        SECOND: begin
                            // Codes with a non-decimal digit never equal a BCD code, so they land in null.
                            if ({tens, units} == CODE_C1)
                                contadorC1 <= bump(contadorC1);
                            else if ({tens, units} == CODE_C2)
                                contadorC2 <= bump(contadorC2);
                            else
                                contadorNull <= bump(contadorNull);
                            VoteStatus <= 1'b1;
                            state      <= IDLE;
                        end
                        default: state <= state;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_urna.sv
module tb_urna;

    localparam int C1 = 'h13;
    localparam int C2 = 'h22;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       valid = 1'b0;
    logic       swap = 1'b0;
    logic       finish = 1'b0;
    logic       VoteStatus;
    logic [7:0] contadorC1;
    logic [7:0] contadorC2;
    logic [7:0] contadorNull;

    int checks = 0;
    int failures = 0;

    // Reference model: digits held as a queue, election open/closed flag, integer tallies.
    int  digs[$];
    bit  closed;
    int  m_c1, m_c2, m_null;
    int  m_vs;

    urna #(.CODE_C1(8'h13), .CODE_C2(8'h22)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digit(digit),
        .valid(valid),
        .swap(swap),
        .finish(finish),
        .VoteStatus(VoteStatus),
        .contadorC1(contadorC1),
        .contadorC2(contadorC2),
        .contadorNull(contadorNull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int add_vote(input int cnt);
`ifdef URNA_SATURATE_EN
        return (cnt >= 255) ? 255 : cnt + 1;
`else
        return (cnt + 1) % 256;
`endif
    endfunction

    task automatic model_reset();
        digs.delete();
        closed = 1'b0;
        m_c1 = 0;
        m_c2 = 0;
        m_null = 0;
        m_vs = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit s, input bit f);
        int code;
        m_vs = 0;
        if (closed) return;
        if (f) begin
            closed = 1'b1;
            digs.delete();
        end else if (s && digs.size() != 0) begin
            digs.delete();
        end else if (v) begin
            if (digs.size() < 2) begin
                digs.push_back(d);
            end else begin
                code = digs[0] * 16 + digs[1];
                if (digs[0] > 9 || digs[1] > 9) m_null = add_vote(m_null);
                else if (code == C1)            m_c1 = add_vote(m_c1);
                else if (code == C2)            m_c2 = add_vote(m_c2);
                else                            m_null = add_vote(m_null);
                m_vs = 1;
                digs.delete();
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".vs"},   int'(VoteStatus),   m_vs);
        chk({tag, ".c1"},   int'(contadorC1),   m_c1);
        chk({tag, ".c2"},   int'(contadorC2),   m_c2);
        chk({tag, ".null"}, int'(contadorNull), m_null);
    endtask

    // Drive inputs (called at a falling edge), let one rising edge pass, update model, check.
    task automatic cyc(input bit v, input int d, input bit s, input bit f, input string tag);
        valid  = v;
        digit  = 4'(d);
        swap   = s;
        finish = f;
        @(posedge clk);
        model_step(v, d, s, f);
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Asynchronous reset applied and released between clock edges.
    task automatic do_reset(input string tag);
        valid  = 1'b0;
        swap   = 1'b0;
        finish = 1'b0;
        rst_n  = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic vote(input int a, input int b, input string tag);
        cyc(1, a, 0, 0, tag);
        cyc(1, b, 0, 0, tag);
        cyc(1, 0, 0, 0, tag);
    endtask

    int pick[5] = '{1, 3, 2, 2, 9};

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("reset");
        cyc(0, 0, 0, 0, "idle");

        // Candidate 1 vote, then a quiet cycle to see the pulse drop.
        vote(1, 3, "c1_vote");
        cyc(0, 0, 0, 0, "c1_after");

        // Candidate 2 then a null vote.
        vote(2, 2, "c2_vote");
        vote(9, 9, "null_vote");

        // Correction mid-entry, then a new vote.
        do_reset("rst2");
        cyc(1, 1, 0, 0, "swap_d1");
        cyc(1, 3, 0, 0, "swap_d2");
        cyc(0, 0, 1, 0, "swap");
        vote(2, 2, "after_swap");

        // Non-decimal digits count as null.
        vote(1, 15, "hex_null");
        vote(10, 3, "hex_null2");

        // Confirm coinciding with finish is discarded; CLOSED ignores everything afterwards.
        cyc(1, 1, 0, 0, "fin_d1");
        cyc(1, 3, 0, 0, "fin_d2");
        cyc(1, 0, 0, 1, "fin_confirm");
        vote(1, 3, "closed_vote");
        cyc(1, 2, 1, 0, "closed_swap");

        // Reset from CLOSED: first edge after release is IDLE.
        do_reset("rst_closed");
        vote(2, 2, "reopen");

        // 256 candidate-1 votes: saturating or wrapping per build.
        do_reset("rst_sat");
        for (int i = 0; i < 256; i++) vote(1, 3, "sat_loop");
`ifdef URNA_SATURATE_EN
        chk("sat_final", int'(contadorC1), 255);
`else
        chk("wrap_final", int'(contadorC1), 0);
`endif
        vote(1, 3, "sat_extra");

        // Randomized traffic with periodic resets.
        do_reset("rst_rand");
        for (int n = 0; n < 3000; n++) begin
            bit v, s, f;
            int d;
            if (n % 400 == 399) do_reset("rand_rst");
            v = ($urandom % 10) < 6;
            d = ($urandom % 2) ? pick[$urandom % 5] : int'($urandom % 16);
            s = ($urandom % 20) == 0;
            f = ($urandom % 600) == 0;
            if (digs.size() == 0 && v) s = 1'b0;
            cyc(v, d, s, f, "rand");
        end

        // Pulse reset low between edges after votes: counters clear at once.
        vote(1, 3, "pre_rst");
        do_reset("final_rst");
        vote(1, 3, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
